// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: state encoding, opcodes, func codes,
// control-word bit positions and instruction-class helpers.
package mc_control_unit_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [3:0] OP_BR_MAX = 4'd3;
    localparam logic [3:0] OP_ADI    = 4'd4;
    localparam logic [3:0] OP_ORI    = 4'd5;
    localparam logic [3:0] OP_LWD    = 4'd7;
    localparam logic [3:0] OP_SWD    = 4'd8;
    localparam logic [3:0] OP_JMP    = 4'd9;
    localparam logic [3:0] OP_RTYPE  = 4'd15;

    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    localparam int unsigned SIG_PCSRC    = 13;
    localparam int unsigned SIG_ALUOP    = 12;
    localparam int unsigned SIG_ALUSRCB  = 10;
    localparam int unsigned SIG_ALUSRCA  = 9;
    localparam int unsigned SIG_REGWRITE = 8;
    localparam int unsigned SIG_REGDST   = 7;
    localparam int unsigned SIG_PCWCOND  = 6;
    localparam int unsigned SIG_PCWRITE  = 5;
    localparam int unsigned SIG_IORD     = 4;
    localparam int unsigned SIG_MEMREAD  = 3;
    localparam int unsigned SIG_MEMWRITE = 2;
    localparam int unsigned SIG_MEMTOREG = 1;
    localparam int unsigned SIG_IRWRITE  = 0;

    function automatic logic is_branch(input logic [3:0] op);
        return op <= OP_BR_MAX;
    endfunction

    // Opcodes with an EX phase; everything else (JMP, unsupported) finishes in ID.
    function automatic logic needs_ex(input logic [3:0] op);
        return is_branch(op) || op == OP_ADI || op == OP_ORI || op == OP_LWD ||
               op == OP_SWD || op == OP_RTYPE;
    endfunction

    function automatic logic retires_in(input state_t st, input logic [3:0] op);
        case (st)
            S_ID:    return !needs_ex(op);
            S_EX:    return is_branch(op);
            S_MEM:   return op == OP_SWD;
            S_WB:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_unit_ctrl_decode.sv
// Combinational decode of (state, opcode) into the 15-bit data-path control word.
module ctrl_decode
    import mc_control_unit_pkg::*;
(
    input  state_t      state,
    input  logic [3:0]  op,
    output logic [14:0] word
);

    always_comb begin
        word = '0;
        case (state)
            S_IF: begin
                word[SIG_MEMREAD] = 1'b1;
                word[SIG_IRWRITE] = 1'b1;
            end
            S_ID: begin
                word[SIG_ALUSRCB +: 2] = 2'd1;
                word[SIG_PCWRITE]      = 1'b1;
                word[SIG_PCSRC +: 2]   = (op == OP_JMP) ? 2'd2 : 2'd0;
            end
            S_EX: begin
                if (op == OP_RTYPE) begin
                    word[SIG_ALUSRCA] = 1'b1;
                    word[SIG_ALUOP]   = 1'b1;
                end else if (op == OP_ADI) begin
                    word[SIG_ALUSRCB +: 2] = 2'd2;
                    word[SIG_ALUOP]        = 1'b1;
                end else if (op == OP_ORI) begin
                    word[SIG_ALUSRCB +: 2] = 2'd3;
                    word[SIG_ALUOP]        = 1'b1;
                end else if (op == OP_LWD || op == OP_SWD) begin
                    word[SIG_ALUSRCA]      = 1'b1;
                    word[SIG_ALUSRCB +: 2] = 2'd2;
                end else if (is_branch(op)) begin
                    word[SIG_ALUSRCA]    = 1'b1;
                    word[SIG_ALUOP]      = 1'b1;
                    word[SIG_PCWCOND]    = 1'b1;
                    word[SIG_PCSRC +: 2] = 2'd1;
                end
            end
            S_MEM: begin
                word[SIG_IORD]     = 1'b1;
                word[SIG_MEMREAD]  = (op == OP_LWD);
                word[SIG_MEMWRITE] = (op == OP_SWD);
            end
            S_WB: begin
                word[SIG_REGWRITE] = 1'b1;
                word[SIG_REGDST]   = (op == OP_RTYPE);
                word[SIG_MEMTOREG] = (op == OP_LWD);
            end
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM driving the data-path control word; IF/MEM stretched by MEM_LATENCY.
// Define CTRL_INST_COUNT_EN to build the retired-instruction counter (else num_inst reads 0).
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned WORD_SIZE   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           opcode,
    input  logic [5:0]           func,
    output logic [14:0]          signal,
    output logic [2:0]           state_o,
    output logic                 inst_done,
    output logic                 halted,
    output logic [WORD_SIZE-1:0] num_inst
);

    localparam int unsigned WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt, wait_n;
    logic [3:0]        op_q, op_n;
    logic [5:0]        func_q, func_n;
    logic [14:0]       dec_word;
    logic              wait_last, done_n;

    // The instruction word is live while in IF, so the decode for ID sees it on the leaving edge.
    assign op_n   = (state == S_IF) ? opcode : op_q;
    assign func_n = (state == S_IF) ? func : func_q;

    always_comb begin
        next_state = state;
        wait_last  = (wait_cnt == WAIT_W'(MEM_LATENCY - 1));
        case (state)
            S_INIT: next_state = S_IF;
            S_IF:   if (wait_last) next_state = S_ID;
            S_ID: begin
                if (op_q == OP_RTYPE && func_q == FN_HLT) next_state = S_HALT;
                else if (needs_ex(op_q))                  next_state = S_EX;
                else                                      next_state = S_IF;
            end
            S_EX: begin
                if (op_q == OP_LWD || op_q == OP_SWD) next_state = S_MEM;
                else if (is_branch(op_q))             next_state = S_IF;
                else                                  next_state = S_WB;
            end
            S_MEM:  if (wait_last) next_state = (op_q == OP_LWD) ? S_WB : S_IF;
            S_WB:   next_state = S_IF;
            S_HALT: next_state = S_HALT;
            default: next_state = S_INIT;
        endcase

        wait_n = ((state == S_IF || state == S_MEM) && next_state == state)
                 ? wait_cnt + 1'b1 : '0;

        // inst_done is registered, so look ahead: will the coming cycle be the final one?
        done_n = retires_in(next_state, op_n) &&
                 (!(next_state == S_IF || next_state == S_MEM) ||
                  wait_n == WAIT_W'(MEM_LATENCY - 1));
    end

    ctrl_decode u_decode (
        .state (next_state),
        .op    (op_n),
        .word  (dec_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_INIT;
            wait_cnt  <= '0;
            op_q      <= '0;
            func_q    <= '0;
            signal    <= '0;
            inst_done <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= next_state;
            wait_cnt  <= wait_n;
            op_q      <= op_n;
            func_q    <= func_n;
            signal    <= dec_word;
            inst_done <= done_n;
            halted    <= (next_state == S_HALT);
        end
    end

    assign state_o = state;

`ifdef CTRL_INST_COUNT_EN
    logic [WORD_SIZE-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset)          count_q <= '0;
        else if (inst_done) count_q <= count_q + 1'b1;
    end

    assign num_inst = count_q;
`else
    assign num_inst = '0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench: two control units (MEM_LATENCY 1 and 3) driven with random instruction streams.
module tb_mc_control_unit;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    typedef struct packed {
        logic [2:0]  st;
        logic [14:0] sig;
        logic        done;
        logic        hlt;
        logic [15:0] num;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  opc [2];
    logic [5:0]  fnc [2];
    logic [14:0] sig_o [2];
    logic [2:0]  st_o [2];
    logic        done_o [2];
    logic        hlt_o [2];
    logic [15:0] num_o [2];

    exp_t q0[$];
    exp_t q1[$];
    int unsigned cnt [2];
    int errors = 0;
    int checks = 0;
    bit final_req = 1'b0;
    bit final_done = 1'b0;

    always #5 clk = ~clk;

    mc_control_unit #(.MEM_LATENCY(LAT0), .WORD_SIZE(16)) u_dut0 (
        .clk(clk), .reset(reset), .opcode(opc[0]), .func(fnc[0]), .signal(sig_o[0]),
        .state_o(st_o[0]), .inst_done(done_o[0]), .halted(hlt_o[0]), .num_inst(num_o[0])
    );

    mc_control_unit #(.MEM_LATENCY(LAT1), .WORD_SIZE(16)) u_dut1 (
        .clk(clk), .reset(reset), .opcode(opc[1]), .func(fnc[1]), .signal(sig_o[1]),
        .state_o(st_o[1]), .inst_done(done_o[1]), .halted(hlt_o[1]), .num_inst(num_o[1])
    );

    // Control word assembled from named fields, MSB field first.
    function automatic logic [14:0] mk(input int pcsrc, input int aluop, input int srcb,
                                       input int srca, input int regw, input int regdst,
                                       input int pcwc, input int pcw, input int iord,
                                       input int mr, input int mw, input int m2r, input int irw);
        int v;
        v = (pcsrc << 13) | (aluop << 12) | (srcb << 10) | (srca << 9) | (regw << 8) |
            (regdst << 7) | (pcwc << 6) | (pcw << 5) | (iord << 4) | (mr << 3) |
            (mw << 2) | (m2r << 1) | irw;
        return 15'(v);
    endfunction

    function automatic logic [15:0] exp_num(input int d);
`ifdef CTRL_INST_COUNT_EN
        return 16'(cnt[d]);
`else
        return 16'(d & 0);
`endif
    endfunction

    function automatic exp_t ent(input int st, input logic [14:0] w);
        exp_t e;
        e.st = 3'(st); e.sig = w; e.done = 1'b0; e.hlt = 1'b0; e.num = '0;
        return e;
    endfunction

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // One instruction: builds its cycle-by-cycle phase list, then drives it; maxn>0 truncates.
    task automatic do_inst(input int d, input int op, input int fn, input int maxn);
        exp_t seq[$];
        exp_t e;
        int L, n;
        bit hlt, is_r, is_br, is_mem, is_ai, retire;
        L      = (d == 0) ? LAT0 : LAT1;
        hlt    = (op == 15 && fn == 29);
        is_r   = (op == 15);
        is_br  = (op <= 3);
        is_mem = (op == 7 || op == 8);
        is_ai  = (op == 4 || op == 5);
        for (int i = 0; i < L; i++) seq.push_back(ent(1, mk(0,0,0,0,0,0,0,0,0,1,0,0,1)));
        seq.push_back(ent(2, mk(op == 9 ? 2 : 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)));
        if (!hlt && (is_r || is_br || is_mem || is_ai)) begin
            if (is_r)         seq.push_back(ent(3, mk(0,1,0,1,0,0,0,0,0,0,0,0,0)));
            else if (op == 4) seq.push_back(ent(3, mk(0,1,2,0,0,0,0,0,0,0,0,0,0)));
            else if (op == 5) seq.push_back(ent(3, mk(0,1,3,0,0,0,0,0,0,0,0,0,0)));
            else if (is_mem)  seq.push_back(ent(3, mk(0,0,2,1,0,0,0,0,0,0,0,0,0)));
            else              seq.push_back(ent(3, mk(1,1,0,1,0,0,1,0,0,0,0,0,0)));
            if (is_mem)
                for (int i = 0; i < L; i++)
                    seq.push_back(ent(4, mk(0,0,0,0,0,0,0,0,1,op == 7,op == 8,0,0)));
            if (op == 7 || is_r || is_ai)
                seq.push_back(ent(5, mk(0,0,0,0,1,is_r,0,0,0,0,0,op == 7,0)));
        end
        retire = !hlt;
        n = (maxn > 0 && maxn < seq.size()) ? maxn : seq.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b0;
            // The word is only meaningful up to the edge that leaves IF.
            opc[d] = (i <= L) ? 4'(op) : 4'($urandom_range(0, 15));
            fnc[d] = (i <= L) ? 6'(fn) : 6'($urandom_range(0, 63));
            e = seq[i];
            e.done = retire && (i == seq.size() - 1);
            e.num = exp_num(d);
            push(d, e);
        end
        if (retire && n == seq.size()) cnt[d]++;
    endtask

    task automatic do_halt(input int d, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            opc[d] = 4'($urandom_range(0, 15));
            fnc[d] = 6'($urandom_range(0, 63));
            e = ent(6, '0);
            e.hlt = 1'b1;
            e.num = exp_num(d);
            push(d, e);
        end
    endtask

    task automatic do_reset(input int n);
        cnt[0] = 0;
        cnt[1] = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1;
            opc[0] = 4'($urandom_range(0, 15));
            opc[1] = 4'($urandom_range(0, 15));
            push(0, ent(0, '0));
            push(1, ent(0, '0));
        end
    endtask

    task automatic rand_inst(input int d);
        int op, fn;
        op = $urandom_range(0, 15);
        fn = $urandom_range(0, 63);
        if (op == 15 && fn == 29) fn = 28;
        do_inst(d, op, fn, 0);
    endtask

    always @(posedge clk) begin
        exp_t e, g;
        #1;
        for (int d = 0; d < 2; d++) begin
            if ((d == 0 ? q0.size() : q1.size()) > 0) begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                g = '{st: st_o[d], sig: sig_o[d], done: done_o[d], hlt: hlt_o[d], num: num_o[d]};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL dut%0d cycle: got st=%0d sig=%h done=%b halt=%b num=%0d, want st=%0d sig=%h done=%b halt=%b num=%0d",
                             d, g.st, g.sig, g.done, g.hlt, g.num, e.st, e.sig, e.done, e.hlt, e.num);
                end
            end
        end
        if (final_req && !final_done) begin
            checks += 2;
            if (q0.size() != 0 || q1.size() != 0) begin
                errors++;
                $display("FAIL drain: got q0=%0d q1=%0d pending, want 0", q0.size(), q1.size());
            end
            final_done = 1'b1;
        end
    end

    initial begin
        opc[0] = '0; opc[1] = '0; fnc[0] = '0; fnc[1] = '0;
        do_reset(2);
        fork
            begin
                do_inst(0, 15, 0, 0);
                do_inst(0, 9, 0, 0);
                repeat (30) rand_inst(0);
                do_inst(0, 15, 29, 0);
                do_halt(0, 100);
            end
            begin
                do_inst(1, 7, 0, 0);
                do_inst(1, 9, 0, 0);
                repeat (30) rand_inst(1);
                do_inst(1, 15, 29, 0);
                do_halt(1, 100);
            end
        join
        do_reset(2);
        fork
            begin
                do_inst(0, 9, 0, 0);
                do_inst(0, 8, 0, 4);
            end
            do_inst(1, 8, 0, 6);
        join
        do_reset(1);
        fork
            repeat (10) rand_inst(0);
            repeat (10) rand_inst(1);
        join
        final_req = 1'b1;
        fork
            wait (final_done);
            repeat (20) @(posedge clk);
        join_any
        if (!final_done) begin
            $display("FAIL monitor: got no drain within 20 cycles, want drain");
            $fatal(1, "monitor stalled");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
